// File: rtl/conv_pool_sched.sv
// Frame scheduler for conv_pool: latches kernels, walks image tiles through the
// shared read port, tracks fixed read + datapath latency and writes pooled
// results in issue order.
module conv_pool_sched #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [ADDR_W-1:0] tile_count,
  input  logic [ADDR_W-1:0] base_in_addr,
  input  logic [ADDR_W-1:0] base_out_addr,
  input  logic [71:0]       kernel_r_in,
  input  logic [71:0]       kernel_g_in,
  input  logic [71:0]       kernel_b_in,
  output logic [71:0]       kernel_r,
  output logic [71:0]       kernel_g,
  output logic [71:0]       kernel_b,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        dp_y,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] tiles_written
);

  // Tap where an issued tile's result is present on dp_y.
  localparam int unsigned TAP  = MEM_LAT + PIPE_LAT;
  localparam int unsigned SR_W = TAP + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tile_count_q, tile_count_d;
  logic [ADDR_W-1:0] base_in_q, base_in_d;
  logic [ADDR_W-1:0] base_out_q, base_out_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [71:0]       kernel_r_q, kernel_r_d;
  logic [71:0]       kernel_g_q, kernel_g_d;
  logic [71:0]       kernel_b_q, kernel_b_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              out_we_q, out_we_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [ADDR_W-1:0] tiles_written_q, tiles_written_d;

  logic              do_issue;
  logic [ADDR_W-1:0] issue_base;
  logic [ADDR_W-1:0] issue_idx;

  // Next-state, read issue and result capture.
  always_comb begin
    state_d         = state_q;
    tile_count_d    = tile_count_q;
    base_in_d       = base_in_q;
    base_out_d      = base_out_q;
    issued_d        = issued_q;
    kernel_r_d      = kernel_r_q;
    kernel_g_d      = kernel_g_q;
    kernel_b_d      = kernel_b_q;
    mem_re_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    out_we_d        = 1'b0;
    out_addr_d      = out_addr_q;
    out_data_d      = out_data_q;
    aborted_d       = aborted_q;
    tiles_written_d = tiles_written_q;
    do_issue        = 1'b0;
    issue_base      = base_in_q;
    issue_idx       = issued_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tile_count_d    = tile_count;
          base_in_d       = base_in_addr;
          base_out_d      = base_out_addr;
          kernel_r_d      = kernel_r_in;
          kernel_g_d      = kernel_g_in;
          kernel_b_d      = kernel_b_in;
          issued_d        = '0;
          tiles_written_d = '0;
          aborted_d       = 1'b0;
          if (tile_count == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
            // First tile goes out on the accepting edge itself.
            if (!pause) begin
              do_issue   = 1'b1;
              issue_base = base_in_addr;
              issue_idx  = '0;
              if (tile_count == ADDR_W'(1)) begin
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d   = S_DRAIN;
          aborted_d = 1'b1;
        end else if (!pause) begin
          do_issue = 1'b1;
          if (issued_q + ADDR_W'(1) == tile_count_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (sr_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_issue) begin
      mem_re_d   = 1'b1;
      mem_addr_d = issue_base + issue_idx;
      issued_d   = issue_idx + ADDR_W'(1);
    end

    sr_d = {sr_q[SR_W-2:0], do_issue};

    // Results return in issue order, so the write counter is the address.
    if (sr_q[TAP]) begin
      out_we_d        = 1'b1;
      out_addr_d      = base_out_q + tiles_written_q;
      out_data_d      = dp_y;
      tiles_written_d = tiles_written_q + ADDR_W'(1);
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      tile_count_q    <= '0;
      base_in_q       <= '0;
      base_out_q      <= '0;
      issued_q        <= '0;
      sr_q            <= '0;
      kernel_r_q      <= '0;
      kernel_g_q      <= '0;
      kernel_b_q      <= '0;
      mem_re_q        <= 1'b0;
      mem_addr_q      <= '0;
      out_we_q        <= 1'b0;
      out_addr_q      <= '0;
      out_data_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
      tiles_written_q <= '0;
    end else begin
      state_q         <= state_d;
      tile_count_q    <= tile_count_d;
      base_in_q       <= base_in_d;
      base_out_q      <= base_out_d;
      issued_q        <= issued_d;
      sr_q            <= sr_d;
      kernel_r_q      <= kernel_r_d;
      kernel_g_q      <= kernel_g_d;
      kernel_b_q      <= kernel_b_d;
      mem_re_q        <= mem_re_d;
      mem_addr_q      <= mem_addr_d;
      out_we_q        <= out_we_d;
      out_addr_q      <= out_addr_d;
      out_data_q      <= out_data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
      tiles_written_q <= tiles_written_d;
    end
  end

  assign kernel_r      = kernel_r_q;
  assign kernel_g      = kernel_g_q;
  assign kernel_b      = kernel_b_q;
  assign mem_re        = mem_re_q;
  assign mem_addr      = mem_addr_q;
  assign out_we        = out_we_q;
  assign out_addr      = out_addr_q;
  assign out_data      = out_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign tiles_written = tiles_written_q;

endmodule

// File: tb/tb_conv_pool_sched.sv
// Bench for conv_pool_sched: directed and random frames against a schedule
// model computed from issue edges, plus a latency-matched datapath model.
module tb_conv_pool_sched;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, pause;
  logic [AW-1:0] tile_count, base_in_addr, base_out_addr;
  logic [71:0]   kernel_r_in, kernel_g_in, kernel_b_in;
  logic [71:0]   kernel_r, kernel_g, kernel_b;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [7:0]    dp_y;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic          busy, done, aborted;
  logic [AW-1:0] tiles_written;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_pool_sched #(.ADDR_W(AW), .MEM_LAT(1), .PIPE_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .tile_count(tile_count), .base_in_addr(base_in_addr), .base_out_addr(base_out_addr),
    .kernel_r_in(kernel_r_in), .kernel_g_in(kernel_g_in), .kernel_b_in(kernel_b_in),
    .kernel_r(kernel_r), .kernel_g(kernel_g), .kernel_b(kernel_b),
    .mem_re(mem_re), .mem_addr(mem_addr), .dp_y(dp_y),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .aborted(aborted), .tiles_written(tiles_written)
  );

  // Image memory (1 cycle) followed by a 3-stage datapath; result = tbl[addr].
  logic [7:0] tbl [256];
  logic [7:0] s1 = 8'd0, s2 = 8'd0, s3 = 8'd0, dp_q = 8'd0;
  always @(posedge clk) begin
    s1   <= tbl[mem_addr[7:0]];
    s2   <= s1;
    s3   <= s2;
    dp_q <= s3;
  end
  assign dp_y = dp_q;

  // Per-edge stimulus plan, indexed by edge offset from the start edge.
  bit p_pl [256];
  bit a_pl [256];
  bit s_pl [256];

  // Frame model state.
  int            fr_iss[$];
  int            fr_d, fr_de;
  bit            fr_abf;
  logic [AW-1:0] fr_bin, fr_bout;
  logic [71:0]   fr_kr, fr_kg, fr_kb;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_plan();
    for (int j = 0; j < 256; j++) begin
      p_pl[j] = 1'b0;
      a_pl[j] = 1'b0;
      s_pl[j] = 1'b0;
    end
  endtask

  function automatic logic [71:0] rnd72();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Expected outputs for the cycle after edge k+c.
  task automatic check_cycle(input int c);
    int            issued_le, writes_le, wi;
    bit            exp_re, exp_we;
    logic [AW-1:0] a;
    issued_le = 0;
    writes_le = 0;
    exp_re    = 1'b0;
    exp_we    = 1'b0;
    wi        = 0;
    for (int i = 0; i < fr_iss.size(); i++) begin
      if (fr_iss[i] <= c) issued_le++;
      if (fr_iss[i] == c) exp_re = 1'b1;
      if (fr_iss[i] + 5 <= c) writes_le++;
      if (fr_iss[i] + 5 == c) begin
        exp_we = 1'b1;
        wi     = i;
      end
    end
    chk("mem_re", 72'(mem_re), 72'(exp_re));
    if (issued_le > 0) chk("mem_addr", 72'(mem_addr), 72'(AW'(fr_bin + AW'(issued_le - 1))));
    chk("out_we", 72'(out_we), 72'(exp_we));
    if (exp_we) begin
      a = AW'(fr_bin + AW'(wi));
      chk("out_addr", 72'(out_addr), 72'(AW'(fr_bout + AW'(wi))));
      chk("out_data", 72'(out_data), 72'(tbl[a[7:0]]));
    end
    chk("tiles_written", 72'(tiles_written), 72'(writes_le));
    chk("done", 72'(done), 72'(c == fr_de));
    chk("busy", 72'(busy), 72'(c <= fr_de));
    chk("aborted", 72'(aborted), 72'(fr_abf && c >= fr_d));
    chk("kernel_r", kernel_r, fr_kr);
    chk("kernel_g", kernel_g, fr_kg);
    chk("kernel_b", kernel_b, fr_kb);
  endtask

  // Runs one frame using the current plan; checks every cycle until idle.
  task automatic run_frame(input int n, input logic [AW-1:0] bin, input logic [AW-1:0] bout,
                           input logic [71:0] kr, input logic [71:0] kg, input logic [71:0] kb);
    fr_iss.delete();
    fr_abf = 1'b0;
    fr_d   = 0;
    fr_bin = bin;
    fr_bout = bout;
    fr_kr = kr;
    fr_kg = kg;
    fr_kb = kb;
    // Issue schedule: abort (ignored on the start edge) wins over pause.
    if (n != 0) begin
      for (int j = 0; j < 250; j++) begin
        if (j > 0 && a_pl[j]) begin
          fr_d   = j;
          fr_abf = 1'b1;
          break;
        end
        if (!p_pl[j]) begin
          fr_iss.push_back(j);
          if (fr_iss.size() == n) begin
            fr_d = j;
            break;
          end
        end
      end
    end
    fr_de = fr_d + 1;
    if (fr_iss.size() > 0 && fr_iss[fr_iss.size()-1] + 6 > fr_de) fr_de = fr_iss[fr_iss.size()-1] + 6;

    @(negedge clk);
    start         = 1'b1;
    tile_count    = AW'(n);
    base_in_addr  = bin;
    base_out_addr = bout;
    kernel_r_in   = kr;
    kernel_g_in   = kg;
    kernel_b_in   = kb;
    pause         = p_pl[0];
    abort         = a_pl[0];
    for (int j = 1; j <= fr_de + 2; j++) begin
      @(negedge clk);
      check_cycle(j - 1);
      start         = (j <= fr_de && j < 256) ? s_pl[j] : 1'b0;
      tile_count    = AW'($urandom_range(0, 20));
      base_in_addr  = AW'($urandom());
      base_out_addr = AW'($urandom());
      kernel_r_in   = rnd72();
      kernel_g_in   = rnd72();
      kernel_b_in   = rnd72();
      pause         = (j < 256) ? p_pl[j] : 1'b0;
      abort         = (j < 256) ? a_pl[j] : 1'b0;
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_all_zero();
    chk("rst_mem_re", 72'(mem_re), 72'(0));
    chk("rst_mem_addr", 72'(mem_addr), 72'(0));
    chk("rst_out_we", 72'(out_we), 72'(0));
    chk("rst_out_addr", 72'(out_addr), 72'(0));
    chk("rst_out_data", 72'(out_data), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_aborted", 72'(aborted), 72'(0));
    chk("rst_tiles_written", 72'(tiles_written), 72'(0));
    chk("rst_kernel_r", kernel_r, 72'(0));
    chk("rst_kernel_g", kernel_g, 72'(0));
    chk("rst_kernel_b", kernel_b, 72'(0));
  endtask

  initial begin
    logic [71:0] k1r, k1g, k1b;
    int          nn, ae;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    tile_count = '0; base_in_addr = '0; base_out_addr = '0;
    kernel_r_in = '0; kernel_g_in = '0; kernel_b_in = '0;
    for (int a = 0; a < 256; a++) tbl[a] = 8'(a + 7);
    clear_plan();
    repeat (2) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    @(negedge clk);

    // Plain frame of 4 tiles.
    run_frame(4, 16'h0000, 16'h0000, rnd72(), rnd72(), rnd72());

    // Pause sampled on edges 2 and 3.
    clear_plan();
    p_pl[2] = 1'b1;
    p_pl[3] = 1'b1;
    run_frame(4, 16'h0000, 16'h0000, rnd72(), rnd72(), rnd72());

    // Abort after two issues.
    clear_plan();
    a_pl[2] = 1'b1;
    run_frame(10, 16'h0000, 16'h0000, rnd72(), rnd72(), rnd72());

    // Empty frame, then output address wrap.
    clear_plan();
    run_frame(0, 16'h0000, 16'h0000, rnd72(), rnd72(), rnd72());
    run_frame(3, 16'h0040, 16'hFFFF, rnd72(), rnd72(), rnd72());

    // Reset in the middle of the drain phase.
    k1r = rnd72(); k1g = rnd72(); k1b = rnd72();
    @(negedge clk);
    start = 1'b1; tile_count = 16'd4; base_in_addr = 16'h0010; base_out_addr = 16'h0100;
    kernel_r_in = k1r; kernel_g_in = k1g; kernel_b_in = k1b;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_out_we", 72'(out_we), 72'(1));
    chk("pre_rst_kernel_r", kernel_r, k1r);
    rst = 1'b1;
    #1;
    check_all_zero();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("post_rst_out_we", 72'(out_we), 72'(0));
      chk("post_rst_busy", 72'(busy), 72'(0));
      chk("post_rst_kernel_r", kernel_r, 72'(0));
    end
    clear_plan();
    run_frame(3, 16'h0020, 16'h0200, rnd72(), rnd72(), rnd72());

    // Start pulses while busy are ignored.
    clear_plan();
    s_pl[2] = 1'b1;
    s_pl[7] = 1'b1;
    s_pl[9] = 1'b1;
    run_frame(5, 16'h0033, 16'h0400, rnd72(), rnd72(), rnd72());

    // Random frames with random image data, pauses, aborts and stray starts.
    for (int a = 0; a < 256; a++) tbl[a] = 8'($urandom());
    for (int f = 0; f < 25; f++) begin
      clear_plan();
      nn = int'($urandom_range(0, 12));
      for (int j = 0; j < 60; j++) p_pl[j] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        ae = int'($urandom_range(1, 16));
        a_pl[ae] = 1'b1;
      end
      for (int j = 1; j < 30; j++) s_pl[j] = ($urandom_range(0, 7) == 0);
      run_frame(nn, AW'($urandom()), (f % 3 == 0) ? AW'(16'hFFFF - AW'($urandom_range(0, 4))) : AW'($urandom()),
                rnd72(), rnd72(), rnd72());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_pool_sched.md
# conv_pool_sched

Frame-level scheduler and configuration controller for the `conv_pool` datapath. On `start` it:
- latches the three 3x3 kernels;
- walks a contiguous range of 4x4 RGB image tiles by driving the shared image-memory read port;
- tracks the fixed memory and datapath latency;
- writes each 8-bit pooled result to the result memory at the matching address, then reports completion.

It sits between the host/top-level control and `conv_pool` plus its image/result memories.

## Interface
Parameters:
- `ADDR_W`, 16, width of image/result addresses and tile counts
- `MEM_LAT`, 1, cycles from `mem_re` to image word valid at datapath input
- `PIPE_LAT`, 3, cycles from image word valid to `dp_y` valid

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin frame; sampled only in IDLE
- `abort`  in  1  stop issuing reads, drain, finish
- `pause`  in  1  suspend read issue while high
- `tile_count`  in  ADDR_W  tiles in frame, sampled with `start`
- `base_in_addr`  in  ADDR_W  first image tile address, sampled with `start`
- `base_out_addr`  in  ADDR_W  first result address, sampled with `start`
- `kernel_r_in`, `kernel_g_in`, `kernel_b_in`  in  72 each  signed 9x8-bit kernels, sampled with `start`
- `kernel_r`, `kernel_g`, `kernel_b`  out  72 each  latched kernels to datapath, stable for the whole frame
- `mem_re`  out  1  image read enable (shared by r/g/b memories)
- `mem_addr`  out  ADDR_W  image read address
- `dp_y`  in  8  datapath result
- `out_we`  out  1  result write enable
- `out_addr`  out  ADDR_W  result write address
- `out_data`  out  8  result write data
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse
- `aborted`  out  1  last frame ended by `abort`; held until next `start`
- `tiles_written`  out  ADDR_W  results written in current/last frame

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on `start`; → DRAIN instead if `tile_count`=0. In both cases latch all sampled inputs, clear `tiles_written`, and clear `aborted`.
- ISSUE: each cycle with `pause`=0, issue one read.
  - Issue sets `mem_re`=1, `mem_addr`=base_in+issued, and pushes a valid bit into a shift register of depth MEM_LAT+PIPE_LAT+1.
  - `pause`=1 gives `mem_re`=0 with `mem_addr` held; an empty slot enters the shift register.
  - After the last issue → DRAIN.
- `abort` in ISSUE → DRAIN immediately; no further issues. `abort` beats `pause`. `abort` is ignored in IDLE, DRAIN and DONE.
- DRAIN: no issues; → DONE when the shift register is empty.
- DONE: `done`=1 for one cycle → IDLE.
- Result capture: when the valid bit reaches tap MEM_LAT+PIPE_LAT, register `dp_y` into `out_data`.
  - Same edge: `out_we`=1 and `out_addr`=base_out+`tiles_written`.
  - `tiles_written` increments with each write.
  - Results stay in issue order, so the write counter is the address source.
- Address arithmetic wraps modulo 2^ADDR_W.
- `start` while busy is ignored.
- Kernel outputs change only on an accepted `start`.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, shift register cleared.
- Reset mid-frame: immediate return to IDLE. In-flight results are discarded with no further `out_we`, and `done` is not pulsed.
- `start` accepted at edge k: tile i is issued (`mem_re`=1) in the cycle after edge k+i, absent pause.
- `out_we` for tile i is high in the cycle after edge k+i+MEM_LAT+PIPE_LAT+1.
  - This is where the `dp_y` sample lands, after edge k+i+MEM_LAT+PIPE_LAT.
- `done` is high in the cycle after the last `out_we` cycle.
- `tile_count`=0: `done` is high in the cycle after edge k+1, with no `mem_re` and no `out_we`.
- `busy` is high from the cycle after edge k through the `done` cycle inclusive.
- Each paused cycle delays all later issues, writes and `done` by one cycle.

## Test plan
- Defaults, base_in=0, base_out=0, tile_count=4, `start` at edge 0, with a datapath model returning `dp_y`=addr+7 → `mem_re` after edges 0..3 at addrs 0..3; `out_we` after edges 5..8, addrs 0..3, data 7..10; `done` after edge 9; `tiles_written`=4.
- `pause` high for 2 cycles after edge 1, tile_count=4 → issues at addrs 0,1, gap, then 2,3; writes shift accordingly; `done` after edge 11; no address skipped or repeated.
- `abort` after 2 issues, tile_count=10 → exactly 2 writes (addrs 0,1); `done` pulses; `aborted`=1; `tiles_written`=2.
- tile_count=0 → `done` after edge 1, no `mem_re`/`out_we`. Then base_out=0xFFFF, tile_count=3 → writes at 0xFFFF, 0x0000, 0x0001.
- `rst` asserted mid-drain → all outputs 0 at once, no further `out_we`. A new `start` with different kernels → `kernel_*` updates only then and stays stable through the frame.
- `start` pulsed again while busy → ignored; frame results and `done` count unchanged (exactly one `done`).
